sram_writing_fsm: RTL and testbench

//  Writer counterpart to the SRAM sample reader. It takes 16-bit audio samples from an upstream

---
 rtl/sram_writing_fsm.sv | 122 ++++++++++++
 tb/tb_sram_writing_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_writing_fsm.sv
// Streams valid/ready samples into consecutive SRAM words from BASE_ADDR to LAST_ADDR,
// framing each write as SETUP, then WE_N low for WE_CYCLES, then HOLD.
module sram_writing_fsm #(
  parameter int                ADDR_W    = 20,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
  parameter int                WE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words
);

  localparam int               CNT_W   = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q;
  logic                load;
  logic                bus_act;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      words_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sample register is pure datapath; it is only meaningful while the bus is driven.
  always_ff @(posedge Clk) begin
    if (load) data_q <= din;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT_DATA;
          addr_d  = BASE_ADDR;
          words_d = '0;
        end
      end
      S_WAIT_DATA: begin
        if (din_valid) begin
          load    = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (cnt_q == WE_LAST) state_d = S_HOLD;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      S_HOLD: begin
        // Word is committed once the hold cycle completes; the last address is terminal.
        words_d = words_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_WAIT_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_act   = (state_q == S_SETUP) || (state_q == S_WRITE) || (state_q == S_HOLD);
  assign din_ready = (state_q == S_WAIT_DATA);
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ   = bus_act ? data_q : {DATA_W{1'bz}};
  assign SRAM_CE_N = ~bus_act;
  assign SRAM_UB_N = ~bus_act;
  assign SRAM_LB_N = ~bus_act;
  assign SRAM_OE_N = 1'b1;
  assign SRAM_WE_N = (state_q != S_WRITE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign words     = words_q;

endmodule

// File: tb/tb_sram_writing_fsm.sv
// Directed/randomised bench for sram_writing_fsm: a behavioural SRAM plus an expected-image
// model of which sample should land at which address and when the strobe should appear.
module tb_sram_writing_fsm;

  localparam int          ADDR_W = 20;
  localparam int          DATA_W = 16;
  localparam logic [19:0] BASE   = 20'd0;
  localparam logic [19:0] LAST   = 20'd3;
  localparam int          WE_CYC = 2;

  logic        Clk;
  logic        reset;
  logic        start;
  logic        din_valid;
  logic [15:0] din;
  logic        din_ready;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
  logic        busy, done;
  logic [20:0] words;

  // Released bus reads back as all ones.
  pullup (SRAM_DQ);

  sram_writing_fsm #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BASE_ADDR(BASE),
    .LAST_ADDR(LAST),
    .WE_CYCLES(WE_CYC)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .start    (start),
    .din_valid(din_valid),
    .din      (din),
    .din_ready(din_ready),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N),
    .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N),
    .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N),
    .busy     (busy),
    .done     (done),
    .words    (words)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          checks;
  int          errors;
  int          pulses;
  int          exp_pulses;
  logic [19:0] exp_addr;
  logic [20:0] exp_words;
  logic [15:0] mem     [0:15];
  logic [15:0] mem_exp [0:15];
  int          gap_idx;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SRAM: a word commits when WE_N rises after a low phase with the chip enabled.
  task automatic monitor();
    logic        low_prev = 1'b0;
    logic        we_prev  = 1'b1;
    logic [3:0]  a_lat    = '0;
    logic [15:0] d_lat    = '0;
    forever begin
      @(negedge Clk);
      if (low_prev && SRAM_WE_N) mem[a_lat] = d_lat;
      if (we_prev === 1'b1 && SRAM_WE_N === 1'b0) pulses++;
      we_prev = SRAM_WE_N;
      if (!SRAM_WE_N && !SRAM_CE_N) begin
        a_lat = SRAM_ADDR[3:0];
        d_lat = SRAM_DQ;
      end
      low_prev = !SRAM_WE_N && !SRAM_CE_N;
      chk("oe_never_low", 32'(SRAM_OE_N), 32'd1);
      if (SRAM_WE_N === 1'b0)
        chk("we_implies_enables", 32'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'd0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr  = BASE;
    exp_words = '0;
    chk("start_flags", 32'({busy, done, din_ready}), 32'b101);
    chk("start_words", 32'(words), 32'd0);
    chk("start_addr", 32'(SRAM_ADDR), 32'(BASE));
  endtask

  task automatic send(input logic [15:0] d, input int gap, input bit hold_start);
    for (int g = 0; g < gap; g++) begin
      start     = hold_start;
      din_valid = 1'b0;
      din       = 16'($urandom);
      tick();
      chk("gap_no_xfer", 32'({din_ready, SRAM_CE_N, busy}), 32'b111);
      chk("gap_addr", 32'(SRAM_ADDR), 32'(exp_addr));
    end
    chk("ready_before_xfer", 32'(din_ready), 32'd1);
    start     = hold_start;
    din       = d;
    din_valid = 1'b1;
    tick();
    start     = 1'b0;
    din_valid = 1'b0;
    din       = ~d;
    chk("setup_bus", 32'({din_ready, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N}), 32'b00001);
    chk("setup_addr", 32'(SRAM_ADDR), 32'(exp_addr));
    chk("setup_dq", 32'(SRAM_DQ), 32'(d));
    for (int k = 0; k < WE_CYC; k++) begin
      tick();
      chk("write_strobe", 32'({SRAM_CE_N, SRAM_WE_N}), 32'b00);
      chk("write_addr", 32'(SRAM_ADDR), 32'(exp_addr));
      chk("write_dq", 32'(SRAM_DQ), 32'(d));
    end
    tick();
    chk("hold_strobe", 32'({SRAM_CE_N, SRAM_WE_N}), 32'b01);
    chk("hold_addr", 32'(SRAM_ADDR), 32'(exp_addr));
    chk("hold_dq", 32'(SRAM_DQ), 32'(d));
    chk("hold_words", 32'(words), 32'(exp_words));
    mem_exp[exp_addr[3:0]] = d;
    exp_words++;
    exp_pulses++;
    tick();
    if (exp_addr == LAST) begin
      chk("end_done_flags", 32'({done, busy, din_ready, SRAM_CE_N}), 32'b1001);
    end else begin
      exp_addr++;
      chk("next_wait_flags", 32'({done, busy, din_ready, SRAM_CE_N}), 32'b0111);
    end
    chk("post_words", 32'(words), 32'(exp_words));
    chk("post_addr", 32'(SRAM_ADDR), 32'(exp_addr));
    chk("dq_released", 32'(SRAM_DQ), 32'hFFFF);
    chk("pulse_count", 32'(pulses), 32'(exp_pulses));
  endtask

  task automatic check_image();
    for (int i = 0; i <= int'(LAST); i++) chk($sformatf("mem_%0d", i), 32'(mem[i]), 32'(mem_exp[i]));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pulses     = 0;
    exp_pulses = 0;
    exp_addr   = BASE;
    exp_words  = '0;
    gap_idx    = 0;
    reset      = 1'b1;
    start      = 1'b0;
    din_valid  = 1'b0;
    din        = '0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    reset = 1'b0;
    chk("reset_flags", 32'({busy, done, din_ready}), 32'b000);
    chk("reset_bus", 32'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N}), 32'b11111);
    chk("reset_dq", 32'(SRAM_DQ), 32'hFFFF);
    chk("reset_words", 32'(words), 32'd0);
    chk("reset_addr", 32'(SRAM_ADDR), 32'(BASE));
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("idle_ignores_valid", 32'({busy, din_ready, SRAM_WE_N}), 32'b001);

    // Single word, then reset in the middle of the second word's strobe.
    do_start();
    send(16'hA5A5, 0, 1'b0);
    chk("t1_mem0", 32'(mem[0]), 32'hA5A5);
    din       = 16'h5A5A;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    chk("t4_in_write", 32'(SRAM_WE_N), 32'd0);
    exp_pulses++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_reset_we", 32'({SRAM_WE_N, SRAM_CE_N, busy, done}), 32'b1100);
    chk("t4_reset_dq", 32'(SRAM_DQ), 32'hFFFF);
    chk("t4_reset_words", 32'(words), 32'd0);
    chk("t4_reset_addr", 32'(SRAM_ADDR), 32'(BASE));

    // Back-to-back fill of the whole range.
    do_start();
    send(16'h1111, 0, 1'b0);
    send(16'h2222, 0, 1'b0);
    send(16'h3333, 0, 1'b0);
    send(16'h4444, 0, 1'b0);
    check_image();
    din       = 16'h5555;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_fifth_refused", 32'({done, busy, din_ready, SRAM_WE_N}), 32'b1001);
      chk("t2_words_held", 32'(words), 32'd4);
    end
    din_valid = 1'b0;
    chk("t2_no_extra_pulse", 32'(pulses), 32'(exp_pulses));
    chk("t2_addr_terminal", 32'(SRAM_ADDR), 32'(LAST));

    // Restart from DONE, then finish the range with growing gaps and start held high.
    do_start();
    send(16'hBEEF, 0, 1'b0);
    chk("t5_mem0", 32'(mem[0]), 32'hBEEF);
    for (int w = 1; w <= int'(LAST); w++) begin
      send(16'($urandom), gap_idx % 8, 1'b1);
      gap_idx++;
    end
    check_image();

    for (int run = 0; run < 2; run++) begin
      do_start();
      for (int w = 0; w <= int'(LAST); w++) begin
        send(16'($urandom), gap_idx % 8, w[0]);
        gap_idx++;
      end
      check_image();
      chk("run_done", 32'({done, busy}), 32'b10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
